ram_hs: RTL and testbench
=========================

RAM_HS -- requirements
Module: ram_hs

Interface
REQ-001 SHALL have parameter DATA_W, default 16: word width in bits, a multiple of BYTE_W.
REQ-002 SHALL have parameter ADDR_W, default 8: address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter BYTE_W, default 8: byte-lane width; NB = DATA_W/BYTE_W lanes.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1: request present.
REQ-007 SHALL have port req_ready, output, 1: request accepted this cycle if req_valid is also high.
REQ-008 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, ADDR_W: word address.
REQ-010 SHALL have port req_wdata, input, DATA_W: write data.
REQ-011 SHALL have port req_be, input, NB: per-lane write enable; ignored on reads.
REQ-012 SHALL have port rsp_valid, output, 1: read data present.
REQ-013 SHALL have port rsp_ready, input, 1: consumer takes the response.
REQ-014 SHALL have port rsp_rdata, output, DATA_W: read data.
REQ-015 SHALL have port init_done, output, 1: memory available for requests.

Function
REQ-016 SHALL accept a request on a rising edge where req_valid && req_ready; a request is never accepted otherwise.
REQ-017 SHALL, on an accepted write, update only lanes i with req_be[i]=1 and leave other lanes unchanged; a write produces no response.
REQ-018 SHALL, on an accepted read, present rsp_valid=1 with mem[req_addr] on rsp_rdata exactly one cycle after acceptance.
REQ-019 SHALL hold rsp_valid and rsp_rdata stable while rsp_valid && !rsp_ready.
REQ-020 SHALL drive req_ready = init_done && (!rsp_valid || rsp_ready), so back-to-back reads sustain one per cycle when rsp_ready=1.
REQ-021 SHALL clear rsp_valid on a cycle where rsp_valid && rsp_ready and no read is accepted.
REQ-022 SHALL leave rsp_valid and rsp_rdata unchanged by an accepted write while a response is pending.
REQ-023 SHALL return the newly written data for a read accepted in the cycle after a write to the same address.
REQ-024 SHALL implement FSM states INIT (clearing) and RUN; init_done = (state == RUN); RUN has no exit except reset.
REQ-025 SHALL treat req_addr values modulo 2**ADDR_W; no out-of-range condition exists.

Reset
REQ-026 SHALL, while rst=1, force state INIT (or RUN per REQ-029), rsp_valid=0, rsp_rdata=0, req_ready=0, and init_done=0.
REQ-027 SHALL never reset the memory array by rst alone; contents persist across reset unless the INIT sweep runs.
REQ-028 SHALL abandon any pending response on reset mid-operation; a read accepted in the cycle rst asserts produces no response.

Configuration
REQ-029 SHALL, with RAM_HS_INIT_CLEAR_EN undefined, enter RUN on the first clock edge after rst deasserts (init_done=1 one cycle after release).
REQ-030 SHALL, with RAM_HS_INIT_CLEAR_EN defined, stay in INIT after reset, writing zero to addresses 0..2**ADDR_W-1, one per cycle, via an ADDR_W-bit counter, then enter RUN; init_done rises 2**ADDR_W cycles after rst deasserts.
REQ-031 SHALL, if rst reasserts during the INIT sweep, restart the sweep from address 0.

Structure
REQ-032 SHALL place the FSM state encoding (INIT, RUN) and default widths in a shared package, ram_hs_pkg.
REQ-033 SHALL put the storage array with per-lane write enables in one sub-module, ram_hs_array; handshake and FSM logic stay in ram_hs.

Verification
REQ-034 SHALL cover: write 0xBEEF to addr 0x10 with be=11, then read 0x10 -> rsp_valid 1 cycle later with rdata=0xBEEF.
REQ-035 SHALL cover: write 0x1234 with be=01 to addr 0x10 holding 0xBEEF, then read -> rdata=0xBE34.
REQ-036 SHALL cover: read addr 0x10 with rsp_ready=0 for 3 cycles -> rsp_valid held, rdata stable, req_ready=0; rsp_ready=1 -> response consumed, req_ready=1.
REQ-037 SHALL cover: reads of addrs 0,1,2 on consecutive cycles with rsp_ready=1 -> three responses on consecutive cycles, in order.
REQ-038 SHALL cover: with RAM_HS_INIT_CLEAR_EN defined and ADDR_W=4, release rst -> init_done rises 16 cycles later and any address reads 0x0000; rst pulse at cycle 5 -> sweep restarts, init_done 16 cycles after second release.
REQ-039 SHALL cover: read accepted, rst asserted the next cycle before rsp_ready -> rsp_valid=0 immediately, with no response after release.

Source files
------------

// File: rtl/ram_hs_pkg.sv
// Shared definitions for ram_hs: FSM state encoding and default geometry.
package ram_hs_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_BYTE_W = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ram_hs_array.sv
// Word-addressed storage with per-lane write enables and combinational read.
// Contents are never reset; each byte lane is a separate array.
module ram_hs_array
    import ram_hs_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned BYTE_W = DEF_BYTE_W
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/BYTE_W-1:0]   wr_be,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data
);

    localparam int unsigned NB    = DATA_W / BYTE_W;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    for (genvar i = 0; i < NB; i++) begin : g_lane
        logic [BYTE_W-1:0] lane_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (wr_en && wr_be[i]) begin
                lane_mem[wr_addr] <= wr_data[i*BYTE_W +: BYTE_W];
            end
        end

        assign rd_data[i*BYTE_W +: BYTE_W] = lane_mem[rd_addr];
    end

endmodule

// File: rtl/ram_hs.sv
// Single-port RAM behind a valid/ready request and response handshake.
// Optional RAM_HS_INIT_CLEAR_EN: zero-fill the whole array after every reset.
module ram_hs
    import ram_hs_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned BYTE_W = DEF_BYTE_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [DATA_W/BYTE_W-1:0]  req_be,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      init_done
);

    localparam int unsigned NB = DATA_W / BYTE_W;

    state_t              state_q, state_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
`ifdef RAM_HS_INIT_CLEAR_EN
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
`endif

    logic                req_fire;
    logic                rd_fire;
    logic                arr_we;
    logic [ADDR_W-1:0]   arr_addr;
    logic [DATA_W-1:0]   arr_wdata;
    logic [NB-1:0]       arr_be;
    logic [DATA_W-1:0]   arr_rdata;

    assign init_done = (state_q == ST_RUN);
    assign req_ready = init_done && (!rsp_valid_q || rsp_ready);
    assign req_fire  = req_valid && req_ready;
    assign rd_fire   = req_fire && !req_we;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        arr_we      = 1'b0;
        arr_addr    = req_addr;
        arr_wdata   = req_wdata;
        arr_be      = req_be;
`ifdef RAM_HS_INIT_CLEAR_EN
        clr_addr_d  = clr_addr_q;
`endif
        case (state_q)
            ST_INIT: begin
`ifdef RAM_HS_INIT_CLEAR_EN
                // The write port is borrowed for the sweep; requests are blocked meanwhile.
                arr_we     = 1'b1;
                arr_addr   = clr_addr_q;
                arr_wdata  = '0;
                arr_be     = '1;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == '1) begin
                    state_d = ST_RUN;
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN: begin
                arr_we = req_fire && req_we;
                if (rd_fire) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = arr_rdata;
                end else if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef RAM_HS_INIT_CLEAR_EN
            clr_addr_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef RAM_HS_INIT_CLEAR_EN
            clr_addr_q  <= clr_addr_d;
`endif
        end
    end

    ram_hs_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYTE_W (BYTE_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_we),
        .wr_addr (arr_addr),
        .wr_data (arr_wdata),
        .wr_be   (arr_be),
        .rd_addr (req_addr),
        .rd_data (arr_rdata)
    );

endmodule

// File: tb/tb_ram_hs.sv
// Self-checking bench for ram_hs: request table, response scoreboard, and
// directed sequences for stall, reset and init timing.
module tb_ram_hs;

`ifdef RAM_HS_INIT_CLEAR_EN
    localparam int AW       = 4;
    localparam int INIT_CYC = 16;
`else
    localparam int AW       = 8;
    localparam int INIT_CYC = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [15:0]   req_wdata = '0;
    logic [1:0]    req_be = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [15:0]   rsp_rdata;
    logic          init_done;

    always #5 clk = ~clk;

    ram_hs #(
        .DATA_W (16),
        .ADDR_W (AW),
        .BYTE_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done)
    );

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];
    logic        m_valid = 1'b0;
    logic        m_init  = 1'b0;
    int          m_cnt   = 0;
    logic        m_rd, m_cons;
    logic        exp_ready;

    assign exp_ready = m_init && (!m_valid || rsp_ready);

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic vec_t mk(logic we, logic [7:0] addr, logic [15:0] wdata,
                                logic [1:0] be, logic [15:0] exp);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.exp = exp;
        return v;
    endfunction

    // Reference handshake model: expected response occupancy and init status.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m_init  = 1'b0;
            m_cnt   = 0;
            exp_q.delete();
        end else begin
            m_rd   = req_valid && exp_ready && !req_we;
            m_cons = m_valid && rsp_ready;
            if (m_cons && exp_q.size() > 0) exp_q.pop_front();
            if (m_rd) m_valid = 1'b1;
            else if (m_cons) m_valid = 1'b0;
            if (!m_init) begin
                m_cnt++;
                if (m_cnt == INIT_CYC) m_init = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst) begin
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_rdata", rsp_rdata, 0);
            check("rst_req_ready", req_ready, 0);
            check("rst_init_done", init_done, 0);
        end else begin
            check("init_done", init_done, m_init);
            check("req_ready", req_ready, exp_ready);
            check("rsp_valid", rsp_valid, m_valid);
            if (m_valid) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
                else check("rsp_rdata", rsp_rdata, exp_q[0]);
            end
        end
    end

    task automatic issue(input vec_t v);
        logic acc = 1'b0;
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = AW'(v.addr);
        req_wdata = v.wdata;
        req_be    = v.be;
        for (int t = 0; t < 50 && !acc; t++) begin
            #1;
            if (req_ready) begin
                acc = 1'b1;
                if (!v.we) exp_q.push_back(v.exp);
            end
            @(negedge clk);
        end
        if (!acc) check("issue_timeout", 0, 1);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (!init_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, n, INIT_CYC);
    endtask

    initial begin
        vecs[0]  = mk(1'b1, 8'h10, 16'hBEEF, 2'b11, 16'h0000);
        vecs[1]  = mk(1'b0, 8'h10, 16'h0000, 2'b00, 16'hBEEF);
        vecs[2]  = mk(1'b1, 8'h10, 16'h1234, 2'b01, 16'h0000);
        vecs[3]  = mk(1'b0, 8'h10, 16'h0000, 2'b11, 16'hBE34);
        vecs[4]  = mk(1'b1, 8'h25, 16'h5A5A, 2'b11, 16'h0000);
        vecs[5]  = mk(1'b1, 8'h25, 16'hA5FF, 2'b10, 16'h0000);
        vecs[6]  = mk(1'b0, 8'h25, 16'h0000, 2'b00, 16'hA55A);
        vecs[7]  = mk(1'b1, 8'h00, 16'h1111, 2'b11, 16'h0000);
        vecs[8]  = mk(1'b1, 8'h01, 16'h2222, 2'b11, 16'h0000);
        vecs[9]  = mk(1'b1, 8'h02, 16'h3333, 2'b11, 16'h0000);
        vecs[10] = mk(1'b0, 8'h00, 16'h0000, 2'b00, 16'h1111);
        vecs[11] = mk(1'b0, 8'h01, 16'h0000, 2'b00, 16'h2222);
        vecs[12] = mk(1'b0, 8'h02, 16'h0000, 2'b00, 16'h3333);
        vecs[13] = mk(1'b0, 8'h25, 16'h0000, 2'b00, 16'hA55A);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_init("init_latency");

        // Reset pulse five cycles into a fresh init period.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_init("init_restart");

`ifdef RAM_HS_INIT_CLEAR_EN
        issue(mk(1'b0, 8'h07, 16'h0000, 2'b00, 16'h0000));
        issue(mk(1'b0, 8'h0F, 16'h0000, 2'b00, 16'h0000));
        idle();
        repeat (2) @(negedge clk);
`endif

        for (int i = 0; i < NV; i++) issue(vecs[i]);
        idle();
        repeat (2) @(negedge clk);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_init("init_after_table");
`ifdef RAM_HS_INIT_CLEAR_EN
        issue(mk(1'b0, 8'h25, 16'h0000, 2'b00, 16'h0000));
`else
        issue(mk(1'b0, 8'h25, 16'h0000, 2'b00, 16'hA55A));
`endif
        idle();
        repeat (2) @(negedge clk);

        // Response back-pressure: held for three cycles, then drained.
        issue(mk(1'b1, 8'h10, 16'hC0DE, 2'b11, 16'h0000));
        rsp_ready = 1'b0;
        issue(mk(1'b0, 8'h10, 16'h0000, 2'b00, 16'hC0DE));
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_rsp_rdata", rsp_rdata, 16'hC0DE);
            check("stall_req_ready", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("drain_req_ready", req_ready, 1);
        @(negedge clk);
        #1;
        check("drain_rsp_valid", rsp_valid, 0);
        @(negedge clk);

        // Reset while a response is pending.
        rsp_ready = 1'b0;
        issue(mk(1'b0, 8'h10, 16'h0000, 2'b00, 16'hC0DE));
        idle();
        #1;
        check("pending_before_rst", rsp_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_abandon_valid", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_init("init_after_abandon");
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("no_rsp_after_rst", rsp_valid, 0);
        end
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
